surf4_pps_gen: RTL and testbench



---
 rtl/surf4_pps_gen.sv | 195 +++++++++++++++++++
 tb/tb_surf4_pps_gen.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/surf4_pps_gen.sv
// rtl/surf4_pps_gen.sv - PPS lock/flywheel generator and debounced external trigger
// Optional build macro: SURF4_PPS_TIMESTAMP_EN (latches trigger time since last pps_o)
module surf4_pps_gen #(
    parameter int unsigned CLK_FREQ   = 33000000,
    parameter int unsigned PERIOD_TOL = 33000,
    parameter int unsigned LOCK_COUNT = 2,
    parameter int unsigned LOST_COUNT = 2,
    parameter int unsigned DEBOUNCE   = 4
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        PPS,
    input  logic        EXT_TRIG,
    output logic        pps_o,
    output logic        pps_locked_o,
    output logic [31:0] pps_count_o,
    output logic [31:0] last_period_o,
    output logic        ext_trig_o,
    output logic [31:0] trig_time_o
);
    localparam logic [31:0] FREE_LAST = 32'(CLK_FREQ - 1);
    localparam logic [31:0] MIN_PER   = 32'(CLK_FREQ - PERIOD_TOL);
    localparam logic [31:0] MAX_PER   = 32'(CLK_FREQ + PERIOD_TOL);
    localparam logic [31:0] FLY_LAST  = 32'(CLK_FREQ + PERIOD_TOL - 1);
    localparam logic [7:0]  LOCK_N    = 8'(LOCK_COUNT);
    localparam logic [7:0]  LOST_N    = 8'(LOST_COUNT);
    localparam logic [7:0]  DEB_N     = 8'(DEBOUNCE);

    typedef enum logic {PPS_FREE, PPS_LOCKED} pps_state_t;
    typedef enum logic [1:0] {TRIG_IDLE, TRIG_HIGH_CHK, TRIG_ARMED_WAIT_LOW} trig_state_t;

    logic        pps_s1_q, pps_s2_q, pps_h_q, pps_s1_d, pps_s2_d, pps_h_d;
    logic        trig_s1_q, trig_s2_q, trig_h_q, trig_s1_d, trig_s2_d, trig_h_d;
    pps_state_t  state_q, state_d;
    trig_state_t tstate_q, tstate_d;
    logic [31:0] cnt_q, cnt_d, edge_cnt_q, edge_cnt_d;
    logic [31:0] pps_count_q, pps_count_d, last_period_q, last_period_d;
    logic [7:0]  good_q, good_d, miss_q, miss_d, deb_q, deb_d;
    logic        armed_q, armed_d, pps_q, pps_d, trig_q, trig_d;
    logic        pps_edge;
    logic [31:0] edge_period, lock_period;

    // Synchronizer chains; the history stage gives the edge detector / debouncer a clean sample
    always_comb begin
        pps_s1_d  = PPS;
        pps_s2_d  = pps_s1_q;
        pps_h_d   = pps_s2_q;
        trig_s1_d = EXT_TRIG;
        trig_s2_d = trig_s1_q;
        trig_h_d  = trig_s2_q;
    end

    assign pps_edge    = pps_s2_q & ~pps_h_q;
    assign edge_period = (edge_cnt_q == 32'hFFFF_FFFF) ? edge_cnt_q : edge_cnt_q + 32'd1;
    assign lock_period = cnt_q + 32'd1;

    // Second timing: free-run, acquisition of an external PPS, and flywheel while locked
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q + 32'd1;
        edge_cnt_d    = edge_period;
        armed_d       = armed_q;
        good_d        = good_q;
        miss_d        = miss_q;
        last_period_d = last_period_q;
        pps_d         = 1'b0;
        if (pps_edge) begin
            edge_cnt_d = 32'd0;
            armed_d    = 1'b1;
            if (armed_q) last_period_d = edge_period;
        end
        case (state_q)
            PPS_FREE: begin
                if (cnt_q == FREE_LAST) pps_d = 1'b1;
                // The first edge after reset only arms the period measurement
                if (pps_edge && armed_q) begin
                    if (edge_period >= MIN_PER && edge_period <= MAX_PER) begin
                        if (good_q + 8'd1 == LOCK_N) begin
                            state_d = PPS_LOCKED;
                            good_d  = 8'd0;
                            miss_d  = 8'd0;
                            pps_d   = 1'b1;
                        end else begin
                            good_d = good_q + 8'd1;
                        end
                    end else begin
                        good_d = 8'd0;
                    end
                end
            end
            default: begin
                // Period here is measured from the last pps_o so a glitch edge cannot shift it
                if (pps_edge && lock_period >= MIN_PER && lock_period <= MAX_PER) begin
                    pps_d  = 1'b1;
                    miss_d = 8'd0;
                end else if (cnt_q == FLY_LAST) begin
                    pps_d = 1'b1;
                    if (miss_q + 8'd1 == LOST_N) begin
                        state_d = PPS_FREE;
                        miss_d  = 8'd0;
                        good_d  = 8'd0;
                    end else begin
                        miss_d = miss_q + 8'd1;
                    end
                end
            end
        endcase
        if (pps_d) cnt_d = 32'd0;
        pps_count_d = pps_count_q + {31'd0, pps_d};
    end

    // External trigger debounce: pulse once after a stable high, re-arm after a stable low
    always_comb begin
        tstate_d = tstate_q;
        deb_d    = deb_q;
        trig_d   = 1'b0;
        case (tstate_q)
            TRIG_IDLE: begin
                if (trig_h_q) begin
                    tstate_d = TRIG_HIGH_CHK;
                    deb_d    = 8'd1;
                end
            end
            TRIG_HIGH_CHK: begin
                if (!trig_h_q) begin
                    tstate_d = TRIG_IDLE;
                    deb_d    = 8'd0;
                end else if (deb_q + 8'd1 == DEB_N) begin
                    tstate_d = TRIG_ARMED_WAIT_LOW;
                    deb_d    = 8'd0;
                    trig_d   = 1'b1;
                end else begin
                    deb_d = deb_q + 8'd1;
                end
            end
            default: begin
                if (trig_h_q) begin
                    deb_d = 8'd0;
                end else if (deb_q + 8'd1 == DEB_N) begin
                    tstate_d = TRIG_IDLE;
                    deb_d    = 8'd0;
                end else begin
                    deb_d = deb_q + 8'd1;
                end
            end
        endcase
    end

    // State and counter registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pps_s1_q <= 1'b0; pps_s2_q <= 1'b0; pps_h_q <= 1'b0;
            trig_s1_q <= 1'b0; trig_s2_q <= 1'b0; trig_h_q <= 1'b0;
            state_q <= PPS_FREE; tstate_q <= TRIG_IDLE;
            cnt_q <= 32'd0; edge_cnt_q <= 32'd0;
            pps_count_q <= 32'd0; last_period_q <= 32'd0;
            good_q <= 8'd0; miss_q <= 8'd0; deb_q <= 8'd0;
            armed_q <= 1'b0; pps_q <= 1'b0; trig_q <= 1'b0;
        end else begin
            pps_s1_q <= pps_s1_d; pps_s2_q <= pps_s2_d; pps_h_q <= pps_h_d;
            trig_s1_q <= trig_s1_d; trig_s2_q <= trig_s2_d; trig_h_q <= trig_h_d;
            state_q <= state_d; tstate_q <= tstate_d;
            cnt_q <= cnt_d; edge_cnt_q <= edge_cnt_d;
            pps_count_q <= pps_count_d; last_period_q <= last_period_d;
            good_q <= good_d; miss_q <= miss_d; deb_q <= deb_d;
            armed_q <= armed_d; pps_q <= pps_d; trig_q <= trig_d;
        end
    end

`ifdef SURF4_PPS_TIMESTAMP_EN
    logic [31:0] trig_time_q, trig_time_d;

    // cnt_d is already zero when pps_o fires in the same cycle, so that case latches 0
    always_comb begin
        trig_time_d = trig_time_q;
        if (trig_d) trig_time_d = cnt_d;
    end

    // Trigger timestamp register
    always_ff @(posedge clk_i) begin
        if (rst_i) trig_time_q <= 32'd0;
        else       trig_time_q <= trig_time_d;
    end

    assign trig_time_o = trig_time_q;
`else
    assign trig_time_o = 32'd0;
`endif

    assign pps_o         = pps_q;
    assign pps_locked_o  = (state_q == PPS_LOCKED);
    assign pps_count_o   = pps_count_q;
    assign last_period_o = last_period_q;
    assign ext_trig_o    = trig_q;
endmodule

// File: tb/tb_surf4_pps_gen.sv
// tb/tb_surf4_pps_gen.sv - directed self-checking bench for surf4_pps_gen
module tb_surf4_pps_gen;
    logic        clk = 1'b0;
    logic        rst_i = 1'b1;
    logic        PPS = 1'b0;
    logic        EXT_TRIG = 1'b0;
    logic        pps_o, pps_locked_o, ext_trig_o;
    logic [31:0] pps_count_o, last_period_o, trig_time_o;

    int cyc = 0;
    int n_checks = 0;
    int n_errors = 0;
    int last_pps_cyc = -1;
    int trig_pulses = 0;
    int base, c0, d0, p;

    surf4_pps_gen #(
        .CLK_FREQ(1000), .PERIOD_TOL(10), .LOCK_COUNT(2), .LOST_COUNT(2), .DEBOUNCE(4)
    ) dut (
        .clk_i(clk), .rst_i(rst_i), .PPS(PPS), .EXT_TRIG(EXT_TRIG),
        .pps_o(pps_o), .pps_locked_o(pps_locked_o), .pps_count_o(pps_count_o),
        .last_period_o(last_period_o), .ext_trig_o(ext_trig_o), .trig_time_o(trig_time_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (pps_o) last_pps_cyc = cyc;
        if (ext_trig_o) trig_pulses = trig_pulses + 1;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks = n_checks + 1;
        if (got !== exp) begin
            n_errors = n_errors + 1;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic wait_cyc(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    task automatic pps_pulse(input int t, input int w);
        wait_cyc(t);
        PPS = 1'b1;
        wait_cyc(t + w);
        PPS = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        check_eq("rst_pps", 32'(pps_o), 32'd0);
        check_eq("rst_locked", 32'(pps_locked_o), 32'd0);
        check_eq("rst_count", pps_count_o, 32'd0);
        check_eq("rst_period", last_period_o, 32'd0);
        check_eq("rst_trig", 32'(ext_trig_o), 32'd0);
        check_eq("rst_ttime", trig_time_o, 32'd0);
        rst_i = 1'b0;
        base = cyc;

        // Free-run with no PPS
        wait_cyc(base + 999);
        check_eq("free_pre", 32'(pps_o), 32'd0);
        wait_cyc(base + 1000);
        check_eq("free_first", 32'(pps_o), 32'd1);
        check_eq("free_cnt1", pps_count_o, 32'd1);
        wait_cyc(base + 1001);
        check_eq("free_single", 32'(pps_o), 32'd0);
        wait_cyc(base + 2000);
        check_eq("free_second", 32'(pps_o), 32'd1);
        wait_cyc(base + 5000);
        check_eq("free_cnt5", pps_count_o, 32'd5);
        check_eq("free_unlocked", 32'(pps_locked_o), 32'd0);

        // Acquire on 1005-cycle edges
        c0 = base + 5100;
        pps_pulse(c0, 20);
        check_eq("arm_period", last_period_o, 32'd0);
        pps_pulse(c0 + 1005, 20);
        check_eq("acq_period", last_period_o, 32'd1005);
        check_eq("acq_unlocked", 32'(pps_locked_o), 32'd0);
        pps_pulse(c0 + 2010, 20);
        check_eq("lock_state", 32'(pps_locked_o), 32'd1);
        check_eq("lock_pps_at", 32'(last_pps_cyc), 32'(c0 + 2013));
        pps_pulse(c0 + 3015, 20);
        check_eq("locked_pps_at", 32'(last_pps_cyc), 32'(c0 + 3018));

        // Glitch 300 cycles after an edge
        pps_pulse(c0 + 3315, 5);
        check_eq("glitch_no_pps", 32'(last_pps_cyc), 32'(c0 + 3018));
        check_eq("glitch_locked", 32'(pps_locked_o), 32'd1);
        check_eq("glitch_period", last_period_o, 32'd300);
        pps_pulse(c0 + 4020, 20);
        check_eq("post_glitch_pps", 32'(last_pps_cyc), 32'(c0 + 4023));
        check_eq("post_glitch_period", last_period_o, 32'd705);

        // PPS stops: two flywheels then free-run
        wait_cyc(c0 + 5032);
        check_eq("fly1_pre", 32'(pps_o), 32'd0);
        wait_cyc(c0 + 5033);
        check_eq("fly1", 32'(pps_o), 32'd1);
        check_eq("fly1_locked", 32'(pps_locked_o), 32'd1);
        wait_cyc(c0 + 6042);
        check_eq("fly_gap", 32'(last_pps_cyc), 32'(c0 + 5033));
        wait_cyc(c0 + 6043);
        check_eq("fly2", 32'(pps_o), 32'd1);
        check_eq("fly2_unlocked", 32'(pps_locked_o), 32'd0);
        wait_cyc(c0 + 7042);
        check_eq("refree_pre", 32'(pps_o), 32'd0);
        wait_cyc(c0 + 7043);
        check_eq("refree", 32'(pps_o), 32'd1);

        // Re-lock, then reset at cnt=500
        d0 = c0 + 7100;
        pps_pulse(d0, 20);
        pps_pulse(d0 + 1005, 20);
        pps_pulse(d0 + 2010, 20);
        check_eq("relock", 32'(pps_locked_o), 32'd1);
        check_eq("relock_pps_at", 32'(last_pps_cyc), 32'(d0 + 2013));
        wait_cyc(d0 + 2513);
        rst_i = 1'b1;
        wait_cyc(d0 + 2514);
        check_eq("mrst_pps", 32'(pps_o), 32'd0);
        check_eq("mrst_locked", 32'(pps_locked_o), 32'd0);
        check_eq("mrst_count", pps_count_o, 32'd0);
        check_eq("mrst_period", last_period_o, 32'd0);
        rst_i = 1'b0;
        base = cyc;
        wait_cyc(base + 999);
        check_eq("mrst_pre", 32'(pps_o), 32'd0);
        wait_cyc(base + 1000);
        check_eq("mrst_first", 32'(pps_o), 32'd1);
        check_eq("mrst_cnt1", pps_count_o, 32'd1);

        // External trigger debounce and timestamp
        p = base + 1000;
        wait_cyc(p + 50);
        EXT_TRIG = 1'b1;
        wait_cyc(p + 53);
        EXT_TRIG = 1'b0;
        wait_cyc(p + 70);
        check_eq("trig_short", 32'(trig_pulses), 32'd0);
        wait_cyc(p + 243);
        EXT_TRIG = 1'b1;
        wait_cyc(p + 247);
        EXT_TRIG = 1'b0;
        wait_cyc(p + 249);
        check_eq("trig_pre", 32'(ext_trig_o), 32'd0);
        wait_cyc(p + 250);
        check_eq("trig_pulse", 32'(ext_trig_o), 32'd1);
`ifdef SURF4_PPS_TIMESTAMP_EN
        check_eq("trig_time", trig_time_o, 32'd250);
`else
        check_eq("trig_time", trig_time_o, 32'd0);
`endif
        wait_cyc(p + 251);
        check_eq("trig_single", 32'(ext_trig_o), 32'd0);
        check_eq("trig_count1", 32'(trig_pulses), 32'd1);
        wait_cyc(p + 400);
        EXT_TRIG = 1'b1;
        wait_cyc(p + 500);
        EXT_TRIG = 1'b0;
        wait_cyc(p + 520);
        check_eq("trig_held", 32'(trig_pulses), 32'd2);
        wait_cyc(p + 993);
        EXT_TRIG = 1'b1;
        wait_cyc(p + 997);
        EXT_TRIG = 1'b0;
        wait_cyc(p + 1000);
        check_eq("same_pps", 32'(pps_o), 32'd1);
        check_eq("same_trig", 32'(ext_trig_o), 32'd1);
        check_eq("same_ttime", trig_time_o, 32'd0);
        wait_cyc(p + 1001);
        check_eq("trig_count3", 32'(trig_pulses), 32'd3);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
